i2s_dac_tx: RTL and testbench
=============================

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter SINGLE_DAC_WIDTH, default 16, meaning bits per channel.
REQ-002 SHALL have parameter DAC_DATA_WIDTH, default 32, meaning stereo word width {left, right}.
REQ-003 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bclk half-period; legal values are >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: transmitter enable.
REQ-007 SHALL have port din, input, DAC_DATA_WIDTH bits: stereo sample from the distortion stage, left in the upper half.
REQ-008 SHALL have port din_valid, input, 1 bit: din is presented this cycle.
REQ-009 SHALL have port din_ready, output, 1 bit: the buffer can accept din.
REQ-010 SHALL have port bclk, output, 1 bit: I2S bit clock.
REQ-011 SHALL have port lrclk, output, 1 bit: I2S word select (0 = left, 1 = right).
REQ-012 SHALL have port sdata, output, 1 bit: I2S serial data, MSB first.
REQ-013 SHALL have port frame_load, output, 1 bit: one-clk pulse when a frame is loaded into the shifter.
REQ-014 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame load finds the buffer empty.

Function
REQ-015 SHALL hold a 2-entry FIFO; din_ready = not full; a write occurs when din_valid and din_ready are both high in the same cycle.
REQ-016 SHALL write din in the same cycle as a frame-load read without loss when the FIFO is not full; the occupancy stays unchanged.
REQ-017 SHALL ignore din_valid while din_ready is low; the FIFO contents SHALL NOT change.
REQ-018 SHALL run a divider counter 0..BCLK_DIV-1 while en is high and toggle bclk at the terminal count; bclk starts low.
REQ-019 SHALL treat each bclk 1->0 toggle as a "fall event"; bit_cnt (5 bits) SHALL advance modulo 32 on each fall event.
REQ-020 SHALL, on a fall event where bit_cnt wraps 31->0, pop the FIFO head into the 32-bit shifter and pulse frame_load.
REQ-021 SHALL, if the FIFO is empty at that wrap, load all zeros, pulse underrun, and not pulse frame_load.
REQ-022 SHALL drive sdata = left[15-k] for bit_cnt k = 0..15, and right[31-k] for k = 16..31; sdata SHALL change only on fall events.
REQ-023 SHALL drive lrclk = 1 for bit_cnt 15..30 and 0 otherwise, so lrclk leads each channel MSB by one bclk (I2S delay).
REQ-024 SHALL, while en is low, force bclk, lrclk and sdata to 0, clear the divider, and hold bit_cnt at 31; the FIFO SHALL keep its contents and remain writable.
REQ-025 SHALL, when en rises, produce the first fall event 2*BCLK_DIV clks later, and that event SHALL load a frame.
REQ-026 SHALL, if en falls mid-frame, abandon the remaining bits of the current frame; the popped sample is not re-sent.
REQ-027 SHALL register all outputs; din_ready SHALL reflect FIFO state of the current cycle (registered count).

Reset
REQ-028 SHALL on rst clear: FIFO empty (din_ready = 1), bclk = 0, lrclk = 0, sdata = 0, frame_load = 0, underrun = 0, divider = 0, bit_cnt = 31, shifter = 0.
REQ-029 SHALL, when rst is asserted mid-frame, take effect immediately (asynchronous); the next frame after release starts per REQ-025.

Structure
REQ-030 SHALL take SINGLE_DAC_WIDTH, DAC_DATA_WIDTH, the BCLK_DIV default and the bit_cnt width from shared package audio_pkg.
REQ-031 SHALL implement the FIFO as sub-module sample_fifo2 (2-deep, DAC_DATA_WIDTH wide, push/pop/full/empty), instantiated once.

Verification
REQ-032 SHALL check: reset, then en = 1, push 0x8001_7FFE -> after 2*BCLK_DIV clks frame_load pulses; sdata over 32 bclks = 1000000000000001 then 0111111111111110; lrclk high exactly for bits 15..30.
REQ-033 SHALL check: en = 1 with the FIFO empty -> underrun pulses at each wrap; sdata stays 0; frame_load never pulses.
REQ-034 SHALL check: push 3 samples back-to-back while en = 0 -> din_ready drops after the second; the third is ignored; after en rises, exactly 2 frames are sent, then underrun.
REQ-035 SHALL check: FIFO at 1 entry, push on the wrap cycle -> occupancy stays 1 and no sample is lost.
REQ-036 SHALL check: rst pulse at bit 20 of a frame -> all outputs are 0 in the same cycle, and din_ready = 1.
REQ-037 SHALL check: BCLK_DIV = 2 and 8 -> the bclk period is 4 and 16 clks respectively, with a 50% duty cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: constants and helpers shared by the audio output path.
//   SINGLE_DAC_WIDTH_DEF : bits per channel
//   DAC_DATA_WIDTH_DEF   : stereo word width {left, right}
//   BCLK_DIV_DEF         : clk cycles per bclk half-period
//   BIT_CNT_W            : width of the I2S bit-slot counter
//   lrclk_for_bit()      : word-select level for a given bit slot
package audio_pkg;

  localparam int SINGLE_DAC_WIDTH_DEF = 16;
  localparam int DAC_DATA_WIDTH_DEF   = 32;
  localparam int BCLK_DIV_DEF         = 4;
  localparam int BIT_CNT_W            = 5;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Word select runs one slot ahead of the data (I2S delay): it goes high on
  // the last left bit and returns low on the last right bit.
  function automatic logic lrclk_for_bit(input bit_cnt_t bit_cnt,
                                         input int single_w,
                                         input int data_w);
    return (int'(bit_cnt) >= single_w - 1) && (int'(bit_cnt) <= data_w - 2);
  endfunction

endpackage

// File: rtl/sample_fifo2.sv
// sample_fifo2: two-entry sample buffer between the distortion stage and the
// I2S shifter. Head data is presented combinationally so a pop can load the
// shifter in the same cycle.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : write data
//   rdata    : head entry
//   full     : two entries held
//   empty    : no entries held
module sample_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: buffers stereo samples and serialises them as I2S (MSB first,
// one-bclk word-select delay) towards an external DAC.
//   clk, rst   : system clock, asynchronous active-high reset
//   en         : transmitter enable; low parks the bus at 0
//   din        : stereo sample {left, right}
//   din_valid  : din presented this cycle
//   din_ready  : buffer has room
//   bclk       : I2S bit clock (clk / (2*BCLK_DIV))
//   lrclk      : word select, 0 = left, 1 = right
//   sdata      : serial data, changes on bclk falling edges
//   frame_load : one-clk pulse when a sample enters the shifter
//   underrun   : one-clk pulse when a frame starts with the buffer empty
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int SINGLE_DAC_WIDTH = SINGLE_DAC_WIDTH_DEF,
  parameter int DAC_DATA_WIDTH   = DAC_DATA_WIDTH_DEF,
  parameter int BCLK_DIV         = BCLK_DIV_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DAC_DATA_WIDTH-1:0] din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic                      bclk,
  output logic                      lrclk,
  output logic                      sdata,
  output logic                      frame_load,
  output logic                      underrun
);

  localparam int                    DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam bit_cnt_t              BIT_LAST = bit_cnt_t'(DAC_DATA_WIDTH - 1);

  logic [DIV_W-1:0]          div_q, div_d;
  logic                      bclk_q, bclk_d;
  logic                      lrclk_q, lrclk_d;
  logic                      sdata_q, sdata_d;
  logic                      frame_load_q, frame_load_d;
  logic                      underrun_q, underrun_d;
  bit_cnt_t                  bit_cnt_q, bit_cnt_d;
  logic [DAC_DATA_WIDTH-1:0] shift_q, shift_d;

  logic                      fall;
  logic                      fifo_push, fifo_pop;
  logic                      fifo_full, fifo_empty;
  logic [DAC_DATA_WIDTH-1:0] fifo_rdata;

  assign fifo_push = din_valid && !fifo_full;

  sample_fifo2 #(
    .WIDTH (DAC_DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    div_d        = div_q;
    bclk_d       = bclk_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    frame_load_d = 1'b0;
    underrun_d   = 1'b0;
    fifo_pop     = 1'b0;
    fall         = 1'b0;

    if (!en) begin
      // Parked: bit_cnt sits at the last slot so the first fall event after
      // enable wraps and loads a fresh frame. Any half-sent frame is dropped.
      div_d     = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
      bit_cnt_d = BIT_LAST;
    end else begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
        fall   = bclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (fall) begin
        bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
        if (bit_cnt_q == BIT_LAST) begin
          fifo_pop     = !fifo_empty;
          frame_load_d = !fifo_empty;
          underrun_d   = fifo_empty;
          shift_d      = fifo_empty ? '0 : fifo_rdata;
        end else begin
          shift_d = shift_q << 1;
        end
        sdata_d = shift_d[DAC_DATA_WIDTH-1];
        lrclk_d = lrclk_for_bit(bit_cnt_d, SINGLE_DAC_WIDTH, DAC_DATA_WIDTH);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      frame_load_q <= 1'b0;
      underrun_q   <= 1'b0;
      bit_cnt_q    <= BIT_LAST;
      shift_q      <= '0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      frame_load_q <= frame_load_d;
      underrun_q   <= underrun_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
    end
  end

  assign din_ready  = !fifo_full;
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign frame_load = frame_load_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: scoreboard bench for i2s_dac_tx. A reference model predicts,
// from enable time and buffer contents, which clock edge starts each frame
// and what it carries; a monitor pops those predictions when the DUT pulses
// and checks the serial word and word-select pattern bit by bit.
module tb_i2s_dac_tx;

  localparam int D     = 4;
  localparam int FRAME = 64 * D;

  typedef struct packed {
    logic        is_underrun;
    logic [31:0] word;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        en_aux = 1'b0;
  logic        din_valid = 1'b0;
  logic [31:0] din = 32'h0;
  logic        din_ready, bclk, lrclk, sdata, frame_load, underrun;
  logic        d2_ready, d2_bclk, d2_lrclk, d2_sdata, d2_fl, d2_ur;
  logic        d8_ready, d8_bclk, d8_lrclk, d8_sdata, d8_fl, d8_ur;

  int          checks = 0;
  int          failures = 0;

  // model state
  logic [31:0] m_fifo[$];
  exp_t        exp_q[$];
  int          en_edges = 0;
  logic [31:0] cyc = 32'd0;

  // monitor state
  exp_t        e;
  logic        active = 1'b0;
  logic        bclk_prev = 1'b0;
  int          nbits = 0;
  logic [31:0] cur_word = 32'h0;
  logic [31:0] cap_s = 32'h0;
  logic [31:0] cap_l = 32'h0;

  // bclk shape measurement on the auxiliary instances
  int          c2 = 0, h2 = 0, per2 = 0, high2 = 0, rises2 = 0;
  int          c8 = 0, h8 = 0, per8 = 0, high8 = 0, rises8 = 0;
  logic        d2_prev = 1'b0, d8_prev = 1'b0;
  logic        got;

  always #5 clk = ~clk;

  i2s_dac_tx #(.BCLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .frame_load(frame_load), .underrun(underrun)
  );

  i2s_dac_tx #(.BCLK_DIV(2)) dut_d2 (
    .clk(clk), .rst(rst), .en(en_aux), .din(32'h0), .din_valid(1'b0),
    .din_ready(d2_ready), .bclk(d2_bclk), .lrclk(d2_lrclk), .sdata(d2_sdata),
    .frame_load(d2_fl), .underrun(d2_ur)
  );

  i2s_dac_tx #(.BCLK_DIV(8)) dut_d8 (
    .clk(clk), .rst(rst), .en(en_aux), .din(32'h0), .din_valid(1'b0),
    .din_ready(d8_ready), .bclk(d8_bclk), .lrclk(d8_lrclk), .sdata(d8_sdata),
    .frame_load(d8_fl), .underrun(d8_ur)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Reference model: frames start on every 2*D-th enabled edge (a bclk fall),
  // and every 32nd fall counting from the first one begins a new frame.
  initial begin : model
    logic full_before;
    int   n;
    forever begin
      @(posedge clk);
      cyc = cyc + 32'd1;
      if (rst) begin
        m_fifo.delete();
        exp_q.delete();
        en_edges = 0;
      end else begin
        full_before = (m_fifo.size() == 2);
        if (en) begin
          en_edges++;
          if (en_edges % (2 * D) == 0) begin
            n = en_edges / (2 * D);
            if (n % 32 == 1) begin
              if (m_fifo.size() > 0) exp_q.push_back('{1'b0, m_fifo.pop_front(), cyc});
              else                   exp_q.push_back('{1'b1, 32'h0, cyc});
            end
          end
        end else begin
          en_edges = 0;
        end
        if (din_valid && !full_before) m_fifo.push_back(din);
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      check("din_ready", 32'(din_ready), 32'(rst ? 1'b1 : (m_fifo.size() < 2)));
      if (!rst && en_edges == 0)
        check("idle_outputs", 32'({bclk, lrclk, sdata}), 32'h0);
      if (rst || en_edges == 0) active = 1'b0;
      if (frame_load || underrun) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=frame_load:%0b,underrun:%0b required=no pulse (t=%0t)",
                   frame_load, underrun, $time);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'({frame_load, underrun}), e.is_underrun ? 32'h1 : 32'h2);
          check("pulse_cycle", cyc, e.cyc);
          cur_word = e.word;
          active   = 1'b1;
          nbits    = 0;
          cap_s    = 32'h0;
          cap_l    = 32'h0;
        end
      end else if (active && bclk && !bclk_prev) begin
        cap_s = {cap_s[30:0], sdata};
        cap_l = {cap_l[30:0], lrclk};
        nbits++;
        if (nbits == 32) begin
          check("frame_sdata", cap_s, cur_word);
          check("frame_lrclk", cap_l, 32'h0001_FFFE);
          active = 1'b0;
        end
      end
      bclk_prev = bclk;
    end
  end

  initial begin : bclk_meter
    forever begin
      @(negedge clk);
      if (d2_bclk && !d2_prev) begin
        per2 = c2; high2 = h2; rises2++; c2 = 0; h2 = 0;
      end
      c2++;
      if (d2_bclk) h2++;
      d2_prev = d2_bclk;
      if (d8_bclk && !d8_prev) begin
        per8 = c8; high8 = h8; rises8++; c8 = 0; h8 = 0;
      end
      c8++;
      if (d8_bclk) h8++;
      d8_prev = d8_bclk;
    end
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({bclk, lrclk, sdata, frame_load, underrun}), 32'h0);
    check("rst_din_ready", 32'(din_ready), 32'h1);
    rst    = 1'b0;
    en_aux = 1'b1;

    // single known frame, then underruns on an empty buffer
    push_word(32'h8001_7FFE);
    en = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);

    check("bclk_div2_period", 32'(per2), 32'd4);
    check("bclk_div2_high", 32'(high2), 32'd2);
    check("bclk_div8_period", 32'(per8), 32'd16);
    check("bclk_div8_high", 32'(high8), 32'd8);
    check("bclk_meter_running", 32'((rises2 > 3) && (rises8 > 3)), 32'h1);

    // three back-to-back pushes while idle: third finds the buffer full
    @(negedge clk);
    din_valid = 1'b1; din = $urandom;
    @(negedge clk);   din = $urandom;
    @(negedge clk);   din = $urandom;
    @(negedge clk);   din_valid = 1'b0;
    en = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // one entry held, push lands on the very edge that pops it
    push_word($urandom);
    en = 1'b1;
    repeat (2 * D - 1) @(negedge clk);
    din = $urandom; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3 * FRAME) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // random traffic, ending with enable dropped part-way through a frame
    en = 1'b1;
    for (int i = 0; i < 8 * FRAME + int'($urandom_range(50, 200)); i++) begin
      @(negedge clk);
      din_valid = ($urandom_range(0, 199) == 0);
      din       = $urandom;
    end
    @(negedge clk);
    din_valid = 1'b0;
    en = 1'b0;
    repeat (10) @(negedge clk);

    // asynchronous reset in the middle of bit 20
    push_word(32'hA5A5_C3C3);
    en  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(negedge clk);
      if (frame_load) got = 1'b1;
    end
    check("pre_rst_frame_load_seen", 32'(got), 32'h1);
    repeat (20 * 2 * D + D) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_outputs", 32'({bclk, lrclk, sdata, frame_load, underrun}), 32'h0);
    check("async_rst_din_ready", 32'(din_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * D) @(negedge clk);
    push_word($urandom);
    repeat (2 * FRAME) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
